serial_bus_master: RTL and testbench
====================================

Name: serial_bus_master

Overview:
- Parametrised master for the 13-bit-framed serial register bus that links the Microzed PL to the Spartan6/Artix7 boards.
- Replaces the fixed 16/16 shift-out register and free-running byte collector with a handshaked command/response engine.
- Adds configurable address/data width, response timeout, framing-error reporting and traffic counters.
- Sits between the PL register-file decode (do-write/do-read strobes) and the ser_out/ser_in pin pair.

Parameters:
- ADDR_W, 16, address width in bits; multiple of 8, range 8..64.
- DATA_W, 16, data width in bits; multiple of 8, range 8..64.
- TIMEOUT, 1023, maximum cycles to wait in WAIT_RSP for the status frame; must be at least 1.

Ports:
- clk  in  1  system clock (fclk0 domain); the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse when a command completes.
- rsp_rdata  out  DATA_W  read data; 0 for writes, timeouts and errors.
- rsp_status  out  8  status byte returned by the remote end.
- rsp_timeout  out  1  qualified by rsp_valid.
- rsp_err  out  1  byte-count mismatch; qualified by rsp_valid.
- busy  out  1  equals !cmd_ready.
- ser_out  out  1  serial line to the remote board; registered.
- ser_in  in  1  serial line from the remote board.
- bytes_sent  out  16  frames transmitted; wraps modulo 2^16.
- bytes_seen  out  16  valid frames received in any state; wraps modulo 2^16.

Behaviour:
- Reset: all outputs and registers go to 0 immediately on rst_n low, and cmd_ready is 1 after the first clock with rst_n high. A reset in mid-operation aborts it: no rsp_valid, ser_out returns to 0.
- Frame format, sent MSB first, 13 bits:
  - 0, 1, flag, byte[7:0], 0, 0.
  - Idle line is 0.
  - Frames are sent back-to-back with no gap.
- Accept: on a cycle where cmd_valid && cmd_ready, latch cmd_*, set busy, and move to SEND. Frame 0, bit 0 appears on ser_out on the next cycle. cmd_valid while busy is ignored.
- Write frame sequence:
  - DATA_W/8 data bytes, MSB byte first;
  - then ADDR_W/8 address bytes, MSB byte first;
  - then a command frame with flag=1 and byte OP_WRITE=8'h01.
- Read frame sequence:
  - ADDR_W/8 address bytes;
  - then a command frame with flag=1 and byte OP_READ=8'h02.
- Counters and timing in SEND:
  - bytes_sent increments by 1 on the last bit of each frame.
  - SEND lasts 13 × nframes cycles, e.g. 65 cycles for a 16/16 write and 39 for a 16-bit read.
  - Then the FSM enters WAIT_RSP and clears the timeout counter.
- Receiver:
  - ser_in is registered once, then shifted into a 12-bit register rx.
  - A frame is valid when rx[11]=1 and rx[1:0]=00; then flag=rx[10] and byte=rx[9:2]. rx is cleared on the same cycle.
  - bytes_seen increments on every valid frame.
  - Bytes received outside WAIT_RSP are counted but discarded.
- WAIT_RSP:
  - Each flag=0 frame shifts its byte into a DATA_W accumulator and increments nrx.
  - A flag=1 frame latches its byte as rsp_status and goes to DONE.
  - The expected nrx is DATA_W/8 for a read and 0 for a write. On mismatch, rsp_err=1 and rsp_rdata=0; otherwise rsp_rdata is the accumulator.
- Timeout: the counter increments every WAIT_RSP cycle. When it reaches TIMEOUT with no flag frame, go to DONE with rsp_timeout=1, rsp_status=0 and rsp_rdata=0.
- A flag frame and the timeout expiring in the same cycle resolve as the frame (no timeout).
- DONE: rsp_valid=1 for exactly one cycle. rsp_* hold their values until the next accept. The next state is IDLE.
- States: IDLE -> SEND -> WAIT_RSP -> DONE -> IDLE.

Decomposition:
- Package serial_link_pkg holds:
  - FRAME_BITS=13, OP_WRITE=8'h01, OP_READ=8'h02;
  - the state enum {IDLE, SEND, WAIT_RSP, DONE};
  - a frame-build function (flag, byte) -> 13-bit word.
- Sub-module serial_frame_rx contains the input register, 12-bit shifter and frame detect. It outputs frame_valid, frame_flag and frame_byte, and is reusable by a future slave.
- Parameter legality is checked with elaboration-time assertions.

Test Plan:
- Reset: hold rst_n=0, then release -> ser_out=0, cmd_ready=1, bytes_sent=0, bytes_seen=0; asserting rst_n low mid-SEND drops ser_out to 0 asynchronously and produces no rsp_valid.
- Write addr 0x0003 data 0x1234:
  - ser_out emits exactly 65 bits starting the cycle after accept: frames 0x12, 0x34, 0x00, 0x03 with flag=0, then 0x01 with flag=1; bytes_sent=5.
  - The model replies with status 0x00 (flag=1) -> rsp_valid pulse, rsp_status=0x00, rsp_err=0, rsp_rdata=0.
- Read addr 0x0001: 39-bit request; the model replies 0xBE, 0xEF, then status 0x00 with flag=1 -> rsp_rdata=0xBEEF, bytes_seen=3, no error.
- Timeout with TIMEOUT=100 and a silent model -> rsp_valid exactly 100 cycles after WAIT_RSP entry, with rsp_timeout=1 and rsp_rdata=0. A second run delivers the status frame on the expiry cycle -> rsp_timeout=0.
- Short reply: a read answered with only status 0x5A (flag=1) -> rsp_err=1, rsp_status=0x5A, rsp_rdata=0. cmd_valid held during busy is ignored: cmd_ready=0 and no second request is sent.
- ADDR_W=24, DATA_W=32: a read of 0xABCDEF sends 52 bits (4 frames); the reply 0xDE, 0xAD, 0xBE, 0xEF, then status 0x00 -> rsp_rdata=0xDEADBEEF. Then force bytes_sent to 0xFFFE and send a 3-frame read -> bytes_sent=0x0001.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Framing constants, FSM state type and frame builder shared by the serial
// register bus master and receiver.
package serial_link_pkg;

    localparam int unsigned FRAME_BITS = 13;
    localparam logic [7:0]  OP_WRITE   = 8'h01;
    localparam logic [7:0]  OP_READ    = 8'h02;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

    // Line order, MSB first: 0, 1, flag, byte[7:0], 0, 0.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic flag, input logic [7:0] data);
        return {2'b01, flag, data, 2'b00};
    endfunction

endpackage

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: input register, 12-bit shifter and frame detect.
// Reports one frame_valid cycle per received frame.
module serial_frame_rx
    import serial_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_in,
    output logic       frame_valid,
    output logic       frame_flag,
    output logic [7:0] frame_byte
);

    logic                  ser_q;
    logic [FRAME_BITS-2:0] rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_q <= 1'b0;
            rx    <= '0;
        end else begin
            ser_q <= ser_in;
            // Clearing drops the next frame's leading 0, which the zeroed rx already represents.
            rx    <= frame_valid ? '0 : {rx[FRAME_BITS-3:0], ser_q};
        end
    end

    assign frame_valid = rx[FRAME_BITS-2] && (rx[1:0] == 2'b00);
    assign frame_flag  = rx[FRAME_BITS-3];
    assign frame_byte  = rx[FRAME_BITS-4 -: 8];

endmodule

// File: rtl/serial_bus_master.sv
// Handshaked command/response master for the 13-bit-framed serial register bus,
// with response timeout, byte-count error reporting and traffic counters.
module serial_bus_master
    import serial_link_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [7:0]        rsp_status,
    output logic              rsp_timeout,
    output logic              rsp_err,
    output logic              busy,
    output logic              ser_out,
    input  logic              ser_in,
    output logic [15:0]       bytes_sent,
    output logic [15:0]       bytes_seen
);

    if (ADDR_W % 8 != 0 || ADDR_W < 8 || ADDR_W > 64) begin : g_bad_addr_w
        $error("ADDR_W must be a multiple of 8 in 8..64");
    end
    if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8 in 8..64");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    localparam int unsigned   PW     = ADDR_W + DATA_W;
    localparam int unsigned   TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [4:0]    NB_WR  = 5'((ADDR_W + DATA_W) / 8);
    localparam logic [4:0]    NB_RD  = 5'(ADDR_W / 8);
    localparam logic [7:0]    NRX_RD = 8'(DATA_W / 8);
    localparam logic [3:0]    TOP_BIT = 4'(FRAME_BITS - 1);

    state_t                state, state_nxt;
    logic                  started, accept;
    logic                  wr_q, sel_wr;
    logic [PW-1:0]         payload_q, sel_payload;
    logic [4:0]            frame_idx, nxt_idx, nbytes, byte_sel;
    logic [3:0]            bit_pos, nxt_pos;
    logic                  frame_end, last_frame, ser_nxt;
    logic [FRAME_BITS-1:0] frame_word;
    logic [TW-1:0]         tcnt;
    logic [DATA_W-1:0]     acc;
    logic [7:0]            nrx;
    logic [15:0]           sent_cnt, seen_cnt;
    logic                  rx_valid, rx_flag;
    logic [7:0]            rx_byte;

    serial_frame_rx u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_in      (ser_in),
        .frame_valid (rx_valid),
        .frame_flag  (rx_flag),
        .frame_byte  (rx_byte)
    );

    assign busy       = !cmd_ready;
    assign accept     = cmd_valid && cmd_ready;
    assign bytes_sent = sent_cnt;
    assign bytes_seen = seen_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = started && (state == IDLE);
        rsp_valid = (state == DONE);
        case (state)
            IDLE:     if (cmd_valid && cmd_ready) state_nxt = SEND;
            SEND:     if (frame_end && last_frame) state_nxt = WAIT_RSP;
            WAIT_RSP: if ((rx_valid && rx_flag) || tcnt == T_LAST) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Look one bit ahead so ser_out stays a plain register; in IDLE this selects frame 0 of the incoming command.
    always_comb begin
        sel_wr      = (state == IDLE) ? cmd_wr : wr_q;
        sel_payload = (state == IDLE) ? {cmd_wdata, cmd_addr} : payload_q;
        nbytes      = sel_wr ? NB_WR : NB_RD;
        frame_end   = (bit_pos == 4'd0);
        last_frame  = (frame_idx == nbytes);
        nxt_idx     = (state == IDLE) ? 5'd0 : (frame_end ? frame_idx + 5'd1 : frame_idx);
        nxt_pos     = (state == IDLE || frame_end) ? TOP_BIT : bit_pos - 4'd1;
        byte_sel    = nbytes - 5'd1 - nxt_idx;
        if (nxt_idx == nbytes)
            frame_word = build_frame(1'b1, sel_wr ? OP_WRITE : OP_READ);
        else
            frame_word = build_frame(1'b0, 8'(sel_payload >> {byte_sel, 3'b000}));
        ser_nxt = 1'b0;
        if ((state == IDLE && accept) || (state == SEND && !(frame_end && last_frame)))
            ser_nxt = frame_word[nxt_pos];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            wr_q        <= 1'b0;
            payload_q   <= '0;
            frame_idx   <= '0;
            bit_pos     <= '0;
            ser_out     <= 1'b0;
            tcnt        <= '0;
            acc         <= '0;
            nrx         <= '0;
            sent_cnt    <= '0;
            seen_cnt    <= '0;
            rsp_rdata   <= '0;
            rsp_status  <= '0;
            rsp_timeout <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            started <= 1'b1;
            ser_out <= ser_nxt;
            if (rx_valid) seen_cnt <= seen_cnt + 16'd1;
            case (state)
                IDLE: if (accept) begin
                    wr_q        <= cmd_wr;
                    payload_q   <= {cmd_wdata, cmd_addr};
                    frame_idx   <= '0;
                    bit_pos     <= TOP_BIT;
                    acc         <= '0;
                    nrx         <= '0;
                    rsp_rdata   <= '0;
                    rsp_status  <= '0;
                    rsp_timeout <= 1'b0;
                    rsp_err     <= 1'b0;
                end
                SEND: begin
                    frame_idx <= nxt_idx;
                    bit_pos   <= nxt_pos;
                    tcnt      <= '0;
                    if (frame_end) sent_cnt <= sent_cnt + 16'd1;
                end
                WAIT_RSP: begin
                    if (rx_valid && !rx_flag) begin
                        acc <= DATA_W'({acc, rx_byte});
                        nrx <= nrx + 8'd1;
                    end
                    if (rx_valid && rx_flag) begin
                        rsp_status <= rx_byte;
                        if (nrx != (wr_q ? 8'd0 : NRX_RD)) rsp_err   <= 1'b1;
                        else                               rsp_rdata <= acc;
                    end else if (tcnt == T_LAST) begin
                        rsp_timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_master.sv
// Self-checking bench for serial_bus_master: a 16/16 instance and a 24/32
// instance, both with TIMEOUT=100, driven by a scripted remote-board model.
module tb_serial_bus_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic [7:0]  status;
        logic        timeout;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_wr = 1'b0, ser_in = 1'b0;
    logic [15:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_timeout, rsp_err, busy, ser_out;
    logic [15:0] rsp_rdata, bytes_sent, bytes_seen;
    logic [7:0]  rsp_status;

    logic        cmd_valid_w = 1'b0, cmd_wr_w = 1'b0, ser_in_w = 1'b0;
    logic [23:0] cmd_addr_w = '0;
    logic [31:0] cmd_wdata_w = '0, rsp_rdata_w;
    logic        cmd_ready_w, rsp_valid_w, rsp_timeout_w, rsp_err_w, busy_w, ser_out_w;
    logic [15:0] bytes_sent_w, bytes_seen_w;
    logic [7:0]  rsp_status_w;

    serial_bus_master #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(100)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .rsp_timeout(rsp_timeout), .rsp_err(rsp_err), .busy(busy),
        .ser_out(ser_out), .ser_in(ser_in), .bytes_sent(bytes_sent), .bytes_seen(bytes_seen)
    );

    serial_bus_master #(.ADDR_W(24), .DATA_W(32), .TIMEOUT(100)) dut_w (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_w), .cmd_ready(cmd_ready_w),
        .cmd_wr(cmd_wr_w), .cmd_addr(cmd_addr_w), .cmd_wdata(cmd_wdata_w),
        .rsp_valid(rsp_valid_w), .rsp_rdata(rsp_rdata_w), .rsp_status(rsp_status_w),
        .rsp_timeout(rsp_timeout_w), .rsp_err(rsp_err_w), .busy(busy_w),
        .ser_out(ser_out_w), .ser_in(ser_in_w), .bytes_sent(bytes_sent_w), .bytes_seen(bytes_seen_w)
    );

    int          checks = 0;
    int          fails  = 0;
    logic [12:0] tx_q[$];
    logic [12:0] obs_tx[$];
    logic [8:0]  reply_q[$];
    rsp_t        rsp_q[$];
    logic [15:0] exp_sent = '0, exp_seen = '0, exp_sent_w = '0, exp_seen_w = '0;

    function automatic logic [12:0] mk_frame(input logic flag, input logic [7:0] b);
        return {1'b0, 1'b1, flag, b, 2'b00};
    endfunction

    task automatic push_request(input bit wr, input logic [63:0] addr, input logic [63:0] data,
                                input int ab, input int db);
        if (wr) for (int i = db - 1; i >= 0; i--) tx_q.push_back(mk_frame(1'b0, data[8*i +: 8]));
        for (int i = ab - 1; i >= 0; i--) tx_q.push_back(mk_frame(1'b0, addr[8*i +: 8]));
        tx_q.push_back(mk_frame(1'b1, wr ? 8'h01 : 8'h02));
    endtask

    // Returns at the falling edge of the first SEND cycle.
    task automatic issue(input bit wide, input bit wr, input logic [63:0] addr,
                         input logic [63:0] data, input bit hold);
        @(negedge clk);
        if (wide) begin
            cmd_wr_w = wr; cmd_addr_w = addr[23:0]; cmd_wdata_w = data[31:0]; cmd_valid_w = 1'b1;
        end else begin
            cmd_wr = wr; cmd_addr = addr[15:0]; cmd_wdata = data[15:0]; cmd_valid = 1'b1;
        end
        @(negedge clk);
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_valid_w = 1'b0;
        end
    endtask

    task automatic capture(input bit wide, input int nfr);
        logic [12:0] w;
        obs_tx.delete();
        for (int f = 0; f < nfr; f++) begin
            for (int b = 12; b >= 0; b--) begin
                if (!(f == 0 && b == 12)) @(negedge clk);
                w[b] = wide ? ser_out_w : ser_out;
            end
            obs_tx.push_back(w);
        end
    endtask

    task automatic drive_reply(input bit wide);
        logic [8:0]  r;
        logic [12:0] w;
        while (reply_q.size() > 0) begin
            r = reply_q.pop_front();
            w = mk_frame(r[8], r[7:0]);
            for (int b = 12; b >= 0; b--) begin
                @(negedge clk);
                if (wide) ser_in_w = w[b];
                else      ser_in   = w[b];
            end
            if (wide) exp_seen_w++;
            else      exp_seen++;
        end
        @(negedge clk);
        ser_in = 1'b0;
        ser_in_w = 1'b0;
    endtask

    task automatic wait_rsp(input bit wide, output rsp_t r, output int cyc, output bit got);
        r = '0; cyc = 0; got = 1'b0;
        while (cyc < 400 && !got) begin
            @(negedge clk);
            cyc++;
            if (wide && rsp_valid_w) begin
                got = 1'b1;
                r = '{rsp_rdata_w, rsp_status_w, rsp_timeout_w, rsp_err_w};
            end else if (!wide && rsp_valid) begin
                got = 1'b1;
                r = '{{16'h0, rsp_rdata}, rsp_status, rsp_timeout, rsp_err};
            end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++; if (ser_out !== 1'b0)    begin fails++; $display("FAIL rst_ser_out: got %b want 0", ser_out); end
        checks++; if (cmd_ready !== 1'b0)  begin fails++; $display("FAIL rst_cmd_ready_low: got %b want 0", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0)  begin fails++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1)  begin fails++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (ser_out !== 1'b0)    begin fails++; $display("FAIL rst_ser_out_after: got %b want 0", ser_out); end
        checks++; if (bytes_sent !== 16'h0) begin fails++; $display("FAIL rst_bytes_sent: got %h want 0000", bytes_sent); end
        checks++; if (bytes_seen !== 16'h0) begin fails++; $display("FAIL rst_bytes_seen: got %h want 0000", bytes_seen); end
    endtask

    task automatic test_write;
        rsp_t r, e; int cyc; bit got; logic [12:0] ef;
        push_request(1'b1, 64'h0003, 64'h1234, 2, 2);
        rsp_q.push_back('{32'h0, 8'h00, 1'b0, 1'b0});
        issue(1'b0, 1'b1, 64'h0003, 64'h1234, 1'b0);
        capture(1'b0, 5);
        exp_sent += 16'd5;
        foreach (obs_tx[i]) begin
            ef = tx_q.pop_front();
            checks++; if (obs_tx[i] !== ef) begin fails++; $display("FAIL wr_frame%0d: got %h want %h", i, obs_tx[i], ef); end
        end
        @(negedge clk);
        checks++; if (ser_out !== 1'b0) begin fails++; $display("FAIL wr_after_65_bits: got %b want 0", ser_out); end
        checks++; if (bytes_sent !== exp_sent) begin fails++; $display("FAIL wr_bytes_sent: got %h want %h", bytes_sent, exp_sent); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy: got %b want 1", busy); end
        reply_q.push_back(9'h100);
        drive_reply(1'b0);
        wait_rsp(1'b0, r, cyc, got);
        e = rsp_q.pop_front();
        checks++; if (!got) begin fails++; $display("FAIL wr_rsp_valid: got none want pulse"); end
        checks++; if (r !== e) begin fails++; $display("FAIL wr_rsp: got %h want %h", r, e); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); end
        checks++; if (rsp_status !== e.status) begin fails++; $display("FAIL wr_rsp_hold: got %h want %h", rsp_status, e.status); end
    endtask

    task automatic test_read;
        rsp_t r, e; int cyc; bit got; logic [12:0] ef;
        push_request(1'b0, 64'h0001, 64'h0, 2, 2);
        rsp_q.push_back('{32'h0000BEEF, 8'h00, 1'b0, 1'b0});
        issue(1'b0, 1'b0, 64'h0001, 64'hFFFF, 1'b0);
        capture(1'b0, 3);
        exp_sent += 16'd3;
        foreach (obs_tx[i]) begin
            ef = tx_q.pop_front();
            checks++; if (obs_tx[i] !== ef) begin fails++; $display("FAIL rd_frame%0d: got %h want %h", i, obs_tx[i], ef); end
        end
        reply_q.push_back(9'h0BE);
        reply_q.push_back(9'h0EF);
        reply_q.push_back(9'h100);
        drive_reply(1'b0);
        wait_rsp(1'b0, r, cyc, got);
        e = rsp_q.pop_front();
        checks++; if (!got) begin fails++; $display("FAIL rd_rsp_valid: got none want pulse"); end
        checks++; if (r !== e) begin fails++; $display("FAIL rd_rsp: got %h want %h", r, e); end
        checks++; if (bytes_seen !== exp_seen) begin fails++; $display("FAIL rd_bytes_seen: got %h want %h", bytes_seen, exp_seen); end
        checks++; if (bytes_sent !== exp_sent) begin fails++; $display("FAIL rd_bytes_sent: got %h want %h", bytes_sent, exp_sent); end
    endtask

    task automatic test_timeout;
        rsp_t r, e; int cyc; bit got; logic [12:0] ef;
        push_request(1'b0, 64'h0042, 64'h0, 2, 2);
        rsp_q.push_back('{32'h0, 8'h00, 1'b1, 1'b0});
        issue(1'b0, 1'b0, 64'h0042, 64'h0, 1'b0);
        capture(1'b0, 3);
        exp_sent += 16'd3;
        foreach (obs_tx[i]) begin
            ef = tx_q.pop_front();
            checks++; if (obs_tx[i] !== ef) begin fails++; $display("FAIL to_frame%0d: got %h want %h", i, obs_tx[i], ef); end
        end
        wait_rsp(1'b0, r, cyc, got);
        e = rsp_q.pop_front();
        checks++; if (!got) begin fails++; $display("FAIL to_rsp_valid: got none want pulse"); end
        checks++; if (cyc - 1 != 100) begin fails++; $display("FAIL to_latency: got %0d want 100", cyc - 1); end
        checks++; if (r !== e) begin fails++; $display("FAIL to_rsp: got %h want %h", r, e); end

        // Status frame completes on the 100th WAIT_RSP cycle (the expiry cycle).
        push_request(1'b1, 64'h0044, 64'h5555, 2, 2);
        rsp_q.push_back('{32'h0, 8'h33, 1'b0, 1'b0});
        issue(1'b0, 1'b1, 64'h0044, 64'h5555, 1'b0);
        capture(1'b0, 5);
        exp_sent += 16'd5;
        foreach (obs_tx[i]) begin
            ef = tx_q.pop_front();
            checks++; if (obs_tx[i] !== ef) begin fails++; $display("FAIL toe_frame%0d: got %h want %h", i, obs_tx[i], ef); end
        end
        repeat (85) @(negedge clk);
        reply_q.push_back(9'h133);
        drive_reply(1'b0);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL toe_early: got %b want 0", rsp_valid); end
        @(negedge clk);
        r = '{{16'h0, rsp_rdata}, rsp_status, rsp_timeout, rsp_err};
        e = rsp_q.pop_front();
        checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL toe_rsp_valid: got %b want 1", rsp_valid); end
        checks++; if (r !== e) begin fails++; $display("FAIL toe_rsp: got %h want %h", r, e); end
    endtask

    task automatic test_short_reply_busy;
        rsp_t r, e; int cyc; bit got; logic [12:0] ef;
        push_request(1'b0, 64'h0007, 64'h0, 2, 2);
        rsp_q.push_back('{32'h0, 8'h5A, 1'b0, 1'b1});
        issue(1'b0, 1'b0, 64'h0007, 64'h0, 1'b1);
        capture(1'b0, 3);
        exp_sent += 16'd3;
        checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL busy_cmd_ready: got %b want 0", cmd_ready); end
        foreach (obs_tx[i]) begin
            ef = tx_q.pop_front();
            checks++; if (obs_tx[i] !== ef) begin fails++; $display("FAIL short_frame%0d: got %h want %h", i, obs_tx[i], ef); end
        end
        reply_q.push_back(9'h15A);
        drive_reply(1'b0);
        wait_rsp(1'b0, r, cyc, got);
        cmd_valid = 1'b0;
        e = rsp_q.pop_front();
        checks++; if (!got) begin fails++; $display("FAIL short_rsp_valid: got none want pulse"); end
        checks++; if (r !== e) begin fails++; $display("FAIL short_rsp: got %h want %h", r, e); end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ser_out !== 1'b0) got = 1'b1;
        end
        checks++; if (got) begin fails++; $display("FAIL busy_no_resend: got activity want idle line"); end
        checks++; if (bytes_sent !== exp_sent) begin fails++; $display("FAIL busy_bytes_sent: got %h want %h", bytes_sent, exp_sent); end
    endtask

    task automatic test_reset_mid;
        bit seen;
        issue(1'b0, 1'b1, 64'h0010, 64'hABCD, 1'b0);
        @(negedge clk);
        checks++; if (ser_out !== 1'b1) begin fails++; $display("FAIL mid_bit1: got %b want 1", ser_out); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ser_out !== 1'b0) begin fails++; $display("FAIL mid_async_ser_out: got %b want 0", ser_out); end
        exp_sent = '0; exp_seen = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin fails++; $display("FAIL mid_no_rsp: got rsp_valid want none"); end
        checks++; if (bytes_sent !== 16'h0) begin fails++; $display("FAIL mid_bytes_sent: got %h want 0000", bytes_sent); end
    endtask

    task automatic test_wrap;
        rsp_t r, e; int cyc; bit got; logic [12:0] ef;
        @(negedge clk);
        force dut.sent_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.sent_cnt;
        @(negedge clk);
        exp_sent = 16'hFFFE;
        checks++; if (bytes_sent !== exp_sent) begin fails++; $display("FAIL wrap_preset: got %h want %h", bytes_sent, exp_sent); end
        push_request(1'b0, 64'h00A5, 64'h0, 2, 2);
        rsp_q.push_back('{32'h00000102, 8'h00, 1'b0, 1'b0});
        issue(1'b0, 1'b0, 64'h00A5, 64'h0, 1'b0);
        capture(1'b0, 3);
        exp_sent += 16'd3;
        foreach (obs_tx[i]) begin
            ef = tx_q.pop_front();
            checks++; if (obs_tx[i] !== ef) begin fails++; $display("FAIL wrap_frame%0d: got %h want %h", i, obs_tx[i], ef); end
        end
        @(negedge clk);
        checks++; if (bytes_sent !== exp_sent) begin fails++; $display("FAIL wrap_bytes_sent: got %h want %h", bytes_sent, exp_sent); end
        reply_q.push_back(9'h001);
        reply_q.push_back(9'h002);
        reply_q.push_back(9'h100);
        drive_reply(1'b0);
        wait_rsp(1'b0, r, cyc, got);
        e = rsp_q.pop_front();
        checks++; if (r !== e || !got) begin fails++; $display("FAIL wrap_rsp: got %h want %h", r, e); end
    endtask

    task automatic test_wide;
        rsp_t r, e; int cyc; bit got; logic [12:0] ef;
        push_request(1'b0, 64'hABCDEF, 64'h0, 3, 4);
        rsp_q.push_back('{32'hDEADBEEF, 8'h00, 1'b0, 1'b0});
        issue(1'b1, 1'b0, 64'hABCDEF, 64'h0, 1'b0);
        capture(1'b1, 4);
        exp_sent_w += 16'd4;
        foreach (obs_tx[i]) begin
            ef = tx_q.pop_front();
            checks++; if (obs_tx[i] !== ef) begin fails++; $display("FAIL wide_frame%0d: got %h want %h", i, obs_tx[i], ef); end
        end
        @(negedge clk);
        checks++; if (ser_out_w !== 1'b0) begin fails++; $display("FAIL wide_after_52_bits: got %b want 0", ser_out_w); end
        reply_q.push_back(9'h0DE);
        reply_q.push_back(9'h0AD);
        reply_q.push_back(9'h0BE);
        reply_q.push_back(9'h0EF);
        reply_q.push_back(9'h100);
        drive_reply(1'b1);
        wait_rsp(1'b1, r, cyc, got);
        e = rsp_q.pop_front();
        checks++; if (!got) begin fails++; $display("FAIL wide_rsp_valid: got none want pulse"); end
        checks++; if (r !== e) begin fails++; $display("FAIL wide_rsp: got %h want %h", r, e); end
        checks++; if (bytes_sent_w !== exp_sent_w) begin fails++; $display("FAIL wide_bytes_sent: got %h want %h", bytes_sent_w, exp_sent_w); end
        checks++; if (bytes_seen_w !== exp_seen_w) begin fails++; $display("FAIL wide_bytes_seen: got %h want %h", bytes_seen_w, exp_seen_w); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_short_reply_busy();
        test_reset_mid();
        test_wrap();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
